quad_encoder_reader: RTL and testbench

- Feedback-side companion to the team's L298N H-bridge driver: reads the motor's quadrature encoder (channels A/B) and reports signed position, rotation direction and speed.
- Sits between the encoder pins and the motor control logic. Closes the loop that the PWM/direction driver opens.
- Sequential pipeline: synchronizer, glitch filter, quadrature state decoder, position counter, windowed speed counter.

---
 rtl/quad_encoder_reader.sv | 196 +++++++++++++++++++
 tb/tb_quad_encoder_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_reader.sv
// quad_encoder_reader
//   Reads the motor's quadrature encoder and reports signed position,
//   last step direction and a windowed speed figure. This is the feedback
//   half of the L298N driver loop.
//   Pipeline: 2-FF synchronizer -> per-channel glitch filter -> quadrature
//   decoder -> position counter, plus an independent speed window.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   enc_a/enc_b encoder channels, asynchronous to clk
//   clr         synchronous clear of position and err
//   position    signed x4 quadrature count, wraps modulo 2^COUNT_W
//   dir         last valid step direction, 1 = forward (A leads B)
//   step        one-cycle pulse per accepted valid transition
//   speed       valid steps counted in the last completed window (saturating)
//   speed_valid one-cycle pulse when speed updates
//   err         sticky flag, set when both channels change together
module quad_encoder_reader #(
   parameter int COUNT_W    = 16,
   parameter int FILTER_LEN = 4,
   parameter int SPEED_WIN  = 100000,
   parameter int SPEED_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enc_a,
   input  logic               enc_b,
   input  logic               clr,
   output logic [COUNT_W-1:0] position,
   output logic               dir,
   output logic               step,
   output logic [SPEED_W-1:0] speed,
   output logic               speed_valid,
   output logic               err
);

   localparam int FCNT_W       = $clog2(FILTER_LEN + 1);
   localparam int PRIME_CYCLES = 2 + FILTER_LEN;
   localparam int PCNT_W       = $clog2(PRIME_CYCLES + 1);
   localparam int WIN_W        = $clog2(SPEED_WIN);

   localparam logic [FCNT_W-1:0]  FILT_LAST  = FCNT_W'(FILTER_LEN - 1);
   localparam logic [PCNT_W-1:0]  PRIME_LAST = PCNT_W'(PRIME_CYCLES - 1);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(SPEED_WIN - 1);
   localparam logic [SPEED_W-1:0] SPEED_MAX  = '1;

   // Channel pairs are packed as {a, b} throughout.
   logic [1:0]             meta;
   logic [1:0]             sync;
   logic [1:0]             filt;
   logic [1:0]             prev;
   logic [1:0][FCNT_W-1:0] fcnt;
   logic [PCNT_W-1:0]      prime_cnt;
   logic                   primed;
   logic                   fwd;
   logic                   rev;
   logic                   bad;
   logic                   edge_inc;
   logic [WIN_W-1:0]       win_cnt;
   logic [SPEED_W-1:0]     edge_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {enc_a, enc_b};
         sync <= meta;
      end
   end

   // Priming waits until the synchronizer holds real pin values, then the
   // filter adopts them wholesale so a resting nonzero state is not decoded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prime_cnt <= '0;
         primed    <= 1'b0;
      end else if (!primed) begin
         if (prime_cnt == PRIME_LAST) begin
            primed <= 1'b1;
         end else begin
            prime_cnt <= prime_cnt + 1'b1;
         end
      end
   end

   // Each channel only moves after its synced value has disagreed for
   // FILTER_LEN consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt <= '0;
         fcnt <= '0;
      end else if (!primed) begin
         fcnt <= '0;
         if (prime_cnt == PRIME_LAST) begin
            filt <= sync;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync[i] != filt[i]) begin
               if (fcnt[i] == FILT_LAST) begin
                  filt[i] <= sync[i];
                  fcnt[i] <= '0;
               end else begin
                  fcnt[i] <= fcnt[i] + 1'b1;
               end
            end else begin
               fcnt[i] <= '0;
            end
         end
      end
   end

   // While unprimed prev tracks sync so that it equals filt at the priming
   // load and the first decoded cycle sees no change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= '0;
      end else if (!primed) begin
         prev <= sync;
      end else begin
         prev <= filt;
      end
   end

   // Forward order is 00->10->11->01->00, i.e. next = {~b, a}.
   always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      bad = 1'b0;
      if (primed && (prev != filt)) begin
         if ((prev ^ filt) == 2'b11) begin
            bad = 1'b1;
         end else if (filt == {~prev[0], prev[1]}) begin
            fwd = 1'b1;
         end else begin
            rev = 1'b1;
         end
      end
   end

   // clr beats a simultaneous step for position, but step and dir still update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step     <= 1'b0;
         dir      <= 1'b0;
         position <= '0;
         err      <= 1'b0;
      end else begin
         step <= fwd | rev;
         if (fwd | rev) begin
            dir <= fwd;
         end
         if (clr) begin
            position <= '0;
         end else if (fwd) begin
            position <= position + 1'b1;
         end else if (rev) begin
            position <= position - 1'b1;
         end
         if (clr) begin
            err <= 1'b0;
         end else if (bad) begin
            err <= 1'b1;
         end
      end
   end

   assign edge_inc = step && (edge_cnt != SPEED_MAX);

   // A step pulse landing in the window's last cycle still belongs to that
   // window, so it is folded into the published speed value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt     <= '0;
         edge_cnt    <= '0;
         speed       <= '0;
         speed_valid <= 1'b0;
      end else begin
         speed_valid <= 1'b0;
         if (win_cnt == WIN_LAST) begin
            win_cnt     <= '0;
            edge_cnt    <= '0;
            speed       <= edge_inc ? edge_cnt + 1'b1 : edge_cnt;
            speed_valid <= 1'b1;
         end else begin
            win_cnt <= win_cnt + 1'b1;
            if (edge_inc) begin
               edge_cnt <= edge_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_quad_encoder_reader.sv
// Bench for quad_encoder_reader. Stimulus changes on the falling edge, so a
// held transition is first sampled on the next rising edge and its step is
// visible exactly LAT samples later. The model schedules expected events per
// sample index and the compare process checks every sample after release.
module tb_quad_encoder_reader;

   localparam int FL   = 4;
   localparam int WIN  = 100;
   localparam int LAT  = 2 + FL + 1;
   localparam int NCYC = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        enc_a;
   logic        enc_b;
   logic        clr;
   logic [15:0] position;
   logic        dir;
   logic        step;
   logic [7:0]  speed;
   logic        speed_valid;
   logic        err;
   logic [15:0] position2;
   logic        dir2;
   logic        step2;
   logic [1:0]  speed2;
   logic        speed_valid2;
   logic        err2;

   int          n_checks = 0;
   int          n_fails  = 0;
   int          cyc;
   bit          checking = 1'b0;
   logic [1:0]  cur;

   int          ev_step [NCYC];
   bit          ev_err  [NCYC];
   bit          ev_clr  [NCYC];

   logic [15:0] exp_pos   = '0;
   bit          exp_dir   = 1'b0;
   bit          exp_err   = 1'b0;
   bit          exp_valid = 1'b0;
   int          exp_speed  = 0;
   int          exp_speed2 = 0;

   always #5 clk = ~clk;

   quad_encoder_reader #(
      .COUNT_W(16), .FILTER_LEN(FL), .SPEED_WIN(WIN), .SPEED_W(8)
   ) dut (
      .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
      .position(position), .dir(dir), .step(step), .speed(speed),
      .speed_valid(speed_valid), .err(err)
   );

   quad_encoder_reader #(
      .COUNT_W(16), .FILTER_LEN(FL), .SPEED_WIN(WIN), .SPEED_W(2)
   ) dut_sat (
      .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
      .position(position2), .dir(dir2), .step(step2), .speed(speed2),
      .speed_valid(speed_valid2), .err(err2)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s at cycle %0d: actual %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [1:0] fwdOf(input logic [1:0] s);
      case (s)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] revOf(input logic [1:0] s);
      case (s)
         2'b10:   return 2'b00;
         2'b11:   return 2'b10;
         2'b01:   return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic alignTo(input int r);
      do @(negedge clk); while (cyc % WIN != r);
   endtask

   // Drive a new {a,b} held for 'hold' cycles and schedule its expected effect.
   task automatic applyStimulus(input logic [1:0] ab, input int hold);
      if (hold >= FL && ab != cur) begin
         if (ab == fwdOf(cur))          ev_step[cyc + LAT] = 1;
         else if (ab == revOf(cur))     ev_step[cyc + LAT] = -1;
         else                           ev_err[cyc + LAT]  = 1'b1;
         cur = ab;
      end
      enc_a = ab[1];
      enc_b = ab[0];
      waitCycles(hold);
   endtask

   task automatic applyClr();
      clr = 1'b1;
      ev_clr[cyc + 1] = 1'b1;
      waitCycles(1);
      clr = 1'b0;
   endtask

   task automatic glitchA(input int width);
      enc_a = ~cur[1];
      waitCycles(width);
      enc_a = cur[1];
      waitCycles(20);
   endtask

   // Step and clr land on the same sample: position must read 0 while step pulses.
   task automatic applyStepWithClr(input logic [1:0] ab);
      ev_step[cyc + LAT] = 1;
      cur   = ab;
      enc_a = ab[1];
      enc_b = ab[0];
      waitCycles(LAT - 1);
      clr = 1'b1;
      ev_clr[cyc + 1] = 1'b1;
      waitCycles(1);
      clr = 1'b0;
      checkOutput("clr_step_step", 32'(step), 32'd1);
      checkOutput("clr_step_pos", 32'(position), 32'd0);
      checkOutput("clr_step_dir", 32'(dir), 32'd1);
   endtask

   // Per-sample comparison against the scheduled model.
   always @(negedge clk) begin
      if (checking) begin
         if (cyc >= NCYC) begin
            $display("[TB] FAIL cycle_budget: actual %0d, required below %0d", cyc, NCYC);
            $fatal(1, "[TB] cycle budget exceeded");
         end
         if (ev_step[cyc] != 0) begin
            exp_pos = exp_pos + 16'(ev_step[cyc]);
            exp_dir = (ev_step[cyc] > 0);
         end
         if (ev_err[cyc]) exp_err = 1'b1;
         if (ev_clr[cyc]) begin
            exp_pos = '0;
            exp_err = 1'b0;
         end
         exp_valid = (cyc > 0) && (cyc % WIN == 0);
         if (exp_valid) begin
            automatic int n = 0;
            for (int j = cyc - WIN; j < cyc; j++) if (ev_step[j] != 0) n++;
            exp_speed  = (n > 255) ? 255 : n;
            exp_speed2 = (n > 3) ? 3 : n;
         end
         checkOutput("step", 32'(step), 32'(ev_step[cyc] != 0));
         checkOutput("position", 32'(position), 32'(exp_pos));
         checkOutput("dir", 32'(dir), 32'(exp_dir));
         checkOutput("err", 32'(err), 32'(exp_err));
         checkOutput("speed_valid", 32'(speed_valid), 32'(exp_valid));
         checkOutput("speed", 32'(speed), 32'(exp_speed));
         checkOutput("sat_step", 32'(step2), 32'(ev_step[cyc] != 0));
         checkOutput("sat_position", 32'(position2), 32'(exp_pos));
         checkOutput("sat_err", 32'(err2), 32'(exp_err));
         checkOutput("sat_dir", 32'(dir2), 32'(exp_dir));
         checkOutput("sat_speed_valid", 32'(speed_valid2), 32'(exp_valid));
         checkOutput("sat_speed", 32'(speed2), 32'(exp_speed2));
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: actual timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      enc_a = 1'b1;
      enc_b = 1'b1;
      clr   = 1'b0;
      rst   = 1'b1;
      cur   = 2'b11;
      waitCycles(3);
      checkOutput("rst_position", 32'(position), 32'd0);
      checkOutput("rst_step", 32'(step), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_dir", 32'(dir), 32'd0);
      checkOutput("rst_speed", 32'(speed), 32'd0);
      checkOutput("rst_speed_valid", 32'(speed_valid), 32'd0);
      rst      = 1'b0;
      checking = 1'b1;

      $display("[TB] priming with encoder resting at 11");
      waitCycles(20);
      checkOutput("prime_err", 32'(err), 32'd0);
      checkOutput("prime_position", 32'(position), 32'd0);

      $display("[TB] eight forward transitions");
      for (int i = 0; i < 8; i++) applyStimulus(fwdOf(cur), 20);
      checkOutput("fwd_position", 32'(position), 32'd8);
      checkOutput("fwd_dir", 32'(dir), 32'd1);

      $display("[TB] three reverse transitions");
      for (int i = 0; i < 3; i++) applyStimulus(revOf(cur), 20);
      checkOutput("rev_position", 32'(position), 32'd5);
      checkOutput("rev_dir", 32'(dir), 32'd0);

      $display("[TB] clear then five reverse steps through zero");
      applyClr();
      checkOutput("clr_position", 32'(position), 32'd0);
      for (int i = 0; i < 5; i++) applyStimulus(revOf(cur), 20);
      checkOutput("wrap_position", 32'(position), 32'h0000_FFFB);

      $display("[TB] glitch rejection and single accepted change");
      glitchA(3);
      checkOutput("glitch_position", 32'(position), 32'h0000_FFFB);
      applyStimulus(fwdOf(cur), 5);
      waitCycles(15);
      checkOutput("single_position", 32'(position), 32'h0000_FFFC);
      checkOutput("single_dir", 32'(dir), 32'd1);

      $display("[TB] illegal double change");
      applyStimulus(~cur, 10);
      waitCycles(5);
      checkOutput("illegal_err", 32'(err), 32'd1);
      checkOutput("illegal_position", 32'(position), 32'h0000_FFFC);
      applyClr();
      checkOutput("illegal_clr_err", 32'(err), 32'd0);
      checkOutput("illegal_clr_position", 32'(position), 32'd0);
      waitCycles(10);

      $display("[TB] clear coinciding with a step");
      applyStepWithClr(fwdOf(cur));
      waitCycles(10);
      applyStimulus(fwdOf(cur), 20);
      checkOutput("post_clr_position", 32'(position), 32'd1);

      $display("[TB] speed windows");
      alignTo(5);
      for (int i = 0; i < 12; i++) applyStimulus(fwdOf(cur), 7);
      alignTo(0);
      checkOutput("speed12_valid", 32'(speed_valid), 32'd1);
      checkOutput("speed12", 32'(speed), 32'd12);
      checkOutput("speed12_sat", 32'(speed2), 32'd3);
      alignTo(0);
      checkOutput("speed0", 32'(speed), 32'd0);
      alignTo(5);
      for (int i = 0; i < 6; i++) applyStimulus(fwdOf(cur), 7);
      alignTo(92);
      applyStimulus(fwdOf(cur), 7);
      checkOutput("boundary_step", 32'(step), 32'd1);
      alignTo(0);
      checkOutput("speed7", 32'(speed), 32'd7);
      checkOutput("speed7_sat", 32'(speed2), 32'd3);
      checkOutput("final_position", 32'(position), 32'd20);

      waitCycles(5);
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
